vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pat_pkg.sv | 58 +++++
 rtl/vga_btn_debounce.sv | 74 +++++++
 rtl/vga_pattern_gen.sv | 141 ++++++++++++++
 tb/tb_vga_pattern_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pat_pkg.sv
// Shared mode encodings, colour constants and box-motion helper for the VGA test-pattern generator.
package vga_pat_pkg;

    localparam logic [1:0] MODE_SOLID   = 2'd0;
    localparam logic [1:0] MODE_BARS    = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;
    localparam logic [1:0] MODE_BOX     = 2'd3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t BAR_WHITE   = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    localparam rgb_t BAR_YELLOW  = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
    localparam rgb_t BAR_CYAN    = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
    localparam rgb_t BAR_GREEN   = '{r: 8'h00, g: 8'hFF, b: 8'h00};
    localparam rgb_t BAR_MAGENTA = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
    localparam rgb_t BAR_RED     = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    localparam rgb_t BAR_BLUE    = '{r: 8'h00, g: 8'h00, b: 8'hFF};
    localparam rgb_t BAR_BLACK   = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t COL_DARK_BLUE = '{r: 8'h00, g: 8'h00, b: 8'h40};

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

    // One frame of bouncing motion on one axis; result is {dir_neg, pos}.
    function automatic logic [10:0] box_step_axis(input logic [9:0] pos, input logic dir_neg,
                                                  input int unsigned act, input int unsigned size,
                                                  input int unsigned step);
        int unsigned p;
        logic [10:0] res;
        p = 32'(pos);
        if (!dir_neg && (p + size + step > act))
            res = {1'b1, 10'(p - step)};
        else if (dir_neg && (p < step))
            res = {1'b0, 10'(p + step)};
        else if (dir_neg)
            res = {1'b1, 10'(p - step)};
        else
            res = {1'b0, 10'(p + step)};
        return res;
    endfunction

endpackage

// File: rtl/vga_btn_debounce.sv
// Two-flop synchroniser and level debouncer for the mode button; emits a registered rise pulse.
// After reset, presses are ignored until the button has been seen released for DEB_CYCLES cycles.
module vga_btn_debounce
    import vga_pat_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 250000
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iBtn,
    output logic oLevel,
    output logic oRise
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic [1:0]       r_sync;
    logic [1:0]       r_vld;
    logic             r_level;
    logic             r_block;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    logic             w_want;
    logic             w_match;
    logic             w_done;
    logic             w_level_nxt;
    logic             w_block_nxt;
    logic             w_rise_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // While blocked the target is a stable release; otherwise it is the opposite of the current level.
    always_comb begin
        w_want      = r_block ? 1'b0 : ~r_level;
        w_match     = r_vld[1] && (r_sync[1] == w_want);
        w_done      = w_match && (r_cnt == CNT_W'(DEB_CYCLES - 1));
        w_level_nxt = r_level;
        w_block_nxt = r_block;
        w_rise_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        if (w_match && !w_done)
            w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_done) begin
            if (r_block) begin
                w_block_nxt = 1'b0;
            end else begin
                w_level_nxt = ~r_level;
                w_rise_nxt  = ~r_level;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_sync  <= '0;
            r_vld   <= '0;
            r_level <= 1'b0;
            r_block <= 1'b1;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], iBtn};
            r_vld   <= {r_vld[0], 1'b1};
            r_level <= w_level_nxt;
            r_block <= w_block_nxt;
            r_rise  <= w_rise_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign oLevel = r_level;
    assign oRise  = r_rise;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: solid, colour bars, checker and (with VGA_PAT_BOX_EN) a bouncing box.
// Mode advances on debounced button presses, applied at the next falling edge of VS.
module vga_pattern_gen
    import vga_pat_pkg::*;
#(
    parameter int unsigned H_ACT      = 640,
    parameter int unsigned V_ACT      = 480,
    parameter int unsigned BOX_SIZE   = 32,
    parameter int unsigned BOX_STEP   = 2,
    parameter int unsigned DEB_CYCLES = 250000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [10:0] iX,
    input  logic [10:0] iY,
    input  logic        iRequest,
    input  logic        iVS,
    input  logic        iMode_btn,
    input  logic [7:0]  iSw_r,
    input  logic [7:0]  iSw_g,
    output logic [7:0]  oRed,
    output logic [7:0]  oGreen,
    output logic [7:0]  oBlue,
    output logic [1:0]  oMode
);

    localparam int unsigned BAR_W = H_ACT / 8;

    logic        r_vs;
    logic        r_pend;
    logic [1:0]  r_mode;
    rgb_t        r_rgb;

    logic        w_btn_level;
    logic        w_btn_rise;
    logic        w_frame;
    logic        w_pend_nxt;
    logic [1:0]  w_mode_inc;
    logic [1:0]  w_mode_nxt;
    logic [10:0] w_bar_idx;
    logic        w_unused;
    rgb_t        w_rgb_nxt;

    vga_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iBtn   (iMode_btn),
        .oLevel (w_btn_level),
        .oRise  (w_btn_rise)
    );

`ifdef VGA_PAT_BOX_EN
    logic [9:0]  r_box_x;
    logic [9:0]  r_box_y;
    logic        r_dir_x;
    logic        r_dir_y;
    logic [10:0] w_step_x;
    logic [10:0] w_step_y;
    logic        w_in_box;

    always_comb begin
        w_step_x = box_step_axis(r_box_x, r_dir_x, H_ACT, BOX_SIZE, BOX_STEP);
        w_step_y = box_step_axis(r_box_y, r_dir_y, V_ACT, BOX_SIZE, BOX_STEP);
        w_in_box = (12'(iX) >= 12'(r_box_x)) && (12'(iX) < 12'(r_box_x) + 12'(BOX_SIZE)) &&
                   (12'(iY) >= 12'(r_box_y)) && (12'(iY) < 12'(r_box_y) + 12'(BOX_SIZE));
    end

    // Box keeps moving every frame regardless of the displayed mode.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_box_x <= '0;
            r_box_y <= '0;
            r_dir_x <= 1'b0;
            r_dir_y <= 1'b0;
        end else if (w_frame) begin
            {r_dir_x, r_box_x} <= w_step_x;
            {r_dir_y, r_box_y} <= w_step_y;
        end
    end

    assign w_mode_inc = r_mode + 2'd1;
    assign w_unused   = w_btn_level;
`else
    logic [31:0] w_unused_cfg;

    assign w_mode_inc   = (r_mode == MODE_CHECKER) ? MODE_SOLID : r_mode + 2'd1;
    assign w_unused     = ^{w_btn_level, iY};
    assign w_unused_cfg = 32'(V_ACT + BOX_SIZE + BOX_STEP);
`endif

    // Presses accumulate into one pending flag, consumed at frame start.
    always_comb begin
        w_frame    = r_vs & ~iVS;
        w_pend_nxt = r_pend | w_btn_rise;
        w_mode_nxt = r_mode;
        if (w_frame) begin
            if (r_pend)
                w_mode_nxt = w_mode_inc;
            w_pend_nxt = w_btn_rise;
        end
    end

    always_comb begin
        w_bar_idx = iX / 11'(BAR_W);
        w_rgb_nxt = BAR_BLACK;
        if (iRequest) begin
            case (r_mode)
                MODE_SOLID:   w_rgb_nxt = '{r: iSw_r, g: iSw_g, b: 8'hFF};
                MODE_BARS:    w_rgb_nxt = (w_bar_idx < 11'd8) ? bar_colour(w_bar_idx[2:0]) : BAR_BLACK;
                MODE_CHECKER: w_rgb_nxt = (iX[5] ^ iY[5]) ? BAR_BLACK : BAR_WHITE;
                default: begin
`ifdef VGA_PAT_BOX_EN
                    w_rgb_nxt = w_in_box ? BAR_WHITE : COL_DARK_BLUE;
`else
                    w_rgb_nxt = BAR_BLACK;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_vs   <= 1'b1;
            r_pend <= 1'b0;
            r_mode <= MODE_SOLID;
            r_rgb  <= '0;
        end else begin
            r_vs   <= iVS;
            r_pend <= w_pend_nxt;
            r_mode <= w_mode_nxt;
            r_rgb  <= w_rgb_nxt;
        end
    end

    assign oRed   = r_rgb.r;
    assign oGreen = r_rgb.g;
    assign oBlue  = r_rgb.b;
    assign oMode  = r_mode;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: directed vectors, button/frame sequences and random pixels vs a model.
module tb_vga_pattern_gen;

    localparam int DEB = 4;
`ifdef VGA_PAT_BOX_EN
    localparam int NMODES = 4;
`else
    localparam int NMODES = 3;
`endif

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [10:0] iX;
    logic [10:0] iY;
    logic        iRequest;
    logic        iVS;
    logic        iMode_btn;
    logic [7:0]  iSw_r;
    logic [7:0]  iSw_g;
    logic [7:0]  oRed;
    logic [7:0]  oGreen;
    logic [7:0]  oBlue;
    logic [1:0]  oMode;

    int checks = 0;
    int errors = 0;
    int m_mode = 0;
    int m_frames = 0;
    bit m_pend = 0;

    always #5 iCLK = ~iCLK;

    vga_pattern_gen #(
        .H_ACT(640), .V_ACT(480), .BOX_SIZE(32), .BOX_STEP(2), .DEB_CYCLES(DEB)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iX(iX), .iY(iY), .iRequest(iRequest), .iVS(iVS),
        .iMode_btn(iMode_btn), .iSw_r(iSw_r), .iSw_g(iSw_g),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oMode(oMode)
    );

    typedef struct {
        int         mode;
        int         x;
        int         y;
        bit         req;
        logic [7:0] sr;
        logic [7:0] sg;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Triangle wave: box bounces between 0 and maxp in steps of 2 per frame.
    function automatic int tri_pos(input int n, input int maxp);
        int half;
        int k;
        half = maxp / 2;
        k = n % (2 * half);
        return (k <= half) ? 2 * k : 2 * (2 * half - k);
    endfunction

    function automatic logic [23:0] model_rgb(input int mode, input int x, input int y, input bit req,
                                              input logic [7:0] sr, input logic [7:0] sg);
        int bx;
        int by;
        int bar;
        bx = tri_pos(m_frames, 608);
        by = tri_pos(m_frames, 448);
        if (!req) return 24'h0;
        case (mode)
            0: return {sr, sg, 8'hFF};
            1: begin
                bar = x / 80;
                case (bar)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'h000000 : 24'hFFFFFF;
            default: return (x >= bx && x < bx + 32 && y >= by && y < by + 32) ? 24'hFFFFFF : 24'h000040;
        endcase
    endfunction

    task automatic do_reset();
        iVS = 1'b1;
        iRequest = 1'b1;
        iSw_r = 8'hAA;
        iSw_g = 8'h55;
        iRST = 1'b1;
        tick();
        tick();
        chk("reset_rgb", 32'({oRed, oGreen, oBlue}), 32'h0);
        chk("reset_mode", 32'(oMode), 32'd0);
        iRST = 1'b0;
        m_mode = 0;
        m_frames = 0;
        m_pend = 0;
    endtask

    task automatic press(input int hold);
        iMode_btn = 1'b1;
        repeat (hold) tick();
        iMode_btn = 1'b0;
        repeat (DEB + 6) tick();
        if (hold >= DEB) m_pend = 1;
    endtask

    task automatic frame();
        iVS = 1'b1;
        tick();
        iVS = 1'b0;
        tick();
        m_frames++;
        if (m_pend) begin
            m_mode = (m_mode + 1) % NMODES;
            m_pend = 0;
        end
        chk("mode", 32'(oMode), 32'(m_mode));
    endtask

    task automatic set_mode(input int target);
        for (int n = 0; n < NMODES && m_mode != target; n++) begin
            press(10);
            frame();
        end
    endtask

    initial begin
        int start;
        iRST = 1'b1; iX = '0; iY = '0; iRequest = 1'b0; iVS = 1'b1;
        iMode_btn = 1'b0; iSw_r = '0; iSw_g = '0;

        vecs[0] = '{0,   0,  0, 1'b1, 8'h12, 8'h34, 24'h1234FF};
        vecs[1] = '{0,   0,  0, 1'b0, 8'h12, 8'h34, 24'h000000};
        vecs[2] = '{1,   0,  0, 1'b1, 8'h00, 8'h00, 24'hFFFFFF};
        vecs[3] = '{1,  80,  0, 1'b1, 8'h00, 8'h00, 24'hFFFF00};
        vecs[4] = '{1, 639,  0, 1'b1, 8'h00, 8'h00, 24'h000000};
        vecs[5] = '{1, 400,  0, 1'b1, 8'h00, 8'h00, 24'hFF0000};
        vecs[6] = '{1, 700,  0, 1'b1, 8'h00, 8'h00, 24'h000000};
        vecs[7] = '{2,   0,  0, 1'b1, 8'h00, 8'h00, 24'hFFFFFF};
        vecs[8] = '{2,  32,  0, 1'b1, 8'h00, 8'h00, 24'h000000};
        vecs[9] = '{2,  32, 32, 1'b1, 8'h00, 8'h00, 24'hFFFFFF};

        do_reset();
        repeat (DEB + 6) tick();

        foreach (vecs[i]) begin
            set_mode(vecs[i].mode);
            chk("vec_mode", 32'(oMode), 32'(vecs[i].mode));
            iX = 11'(vecs[i].x);
            iY = 11'(vecs[i].y);
            iRequest = vecs[i].req;
            iSw_r = vecs[i].sr;
            iSw_g = vecs[i].sg;
            tick();
            chk($sformatf("vec%0d_rgb", i), 32'({oRed, oGreen, oBlue}), 32'(vecs[i].exp));
        end

        // Short press is rejected; two presses in one frame advance once; no press, no advance.
        press(3);
        frame();
        press(10);
        press(10);
        frame();
        frame();

        // Reset during a debounce with the button still held.
        iMode_btn = 1'b1;
        repeat (4) tick();
        do_reset();
        repeat (20) tick();
        frame();
        iMode_btn = 1'b0;
        repeat (DEB + 6) tick();
        frame();
        press(10);
        frame();
        chk("rearm_mode", 32'(oMode), 32'd1);

        // Random pixels in every mode against the model.
        start = m_mode;
        for (int k = 0; k < NMODES; k++) begin
            set_mode((start + k) % NMODES);
            for (int c = 0; c < 150; c++) begin
                logic [23:0] exp;
                iX = 11'($urandom_range(0, 1023));
                iY = 11'($urandom_range(0, 600));
                iRequest = ($urandom_range(0, 3) != 0);
                iSw_r = 8'($urandom);
                iSw_g = 8'($urandom);
                exp = model_rgb(m_mode, int'(iX), int'(iY), iRequest, iSw_r, iSw_g);
                tick();
                chk("rand_rgb", 32'({oRed, oGreen, oBlue}), 32'(exp));
            end
        end

`ifdef VGA_PAT_BOX_EN
        // Box trajectory over enough frames to bounce on both axes.
        for (int f = 0; f < 700; f++) begin
            frame();
            chk("box_x", 32'(dut.r_box_x), 32'(tri_pos(m_frames, 608)));
            chk("box_y", 32'(dut.r_box_y), 32'(tri_pos(m_frames, 448)));
            chk("box_in_bounds", 32'((dut.r_box_x <= 10'd608) && (dut.r_box_y <= 10'd448)), 32'd1);
        end
        set_mode(3);
        for (int c = 0; c < 100; c++) begin
            logic [23:0] exp;
            iX = 11'(tri_pos(m_frames, 608) + $urandom_range(0, 40) - 4);
            iY = 11'(tri_pos(m_frames, 448) + $urandom_range(0, 40) - 4);
            iRequest = 1'b1;
            exp = model_rgb(m_mode, int'(iX), int'(iY), 1'b1, 8'h0, 8'h0);
            tick();
            chk("box_rgb", 32'({oRed, oGreen, oBlue}), 32'(exp));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
